// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing types and defaults for the bundling datapath.
// Holds the hypervector type and the bundler FSM state encoding.
package hdc_pkg;

  localparam int HV_DIM = 64;
  localparam int CNT_W  = 8;

  typedef logic [HV_DIM-1:0] hv_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    THRESH,
    OUT
  } bundler_state_e;

endpackage

// File: rtl/hv_bit_counter.sv
// One bundling dimension: popcount of accepted sample bits plus registered majority decision.
// The decision register updates only in THRESH and holds through OUT under backpressure.
module hv_bit_counter #(
  parameter int CNT_W = hdc_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             thresh,
  input  logic             tie_bit,
  input  logic [CNT_W-1:0] n_reg,
  output logic             maj_bit
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W+1:0] twice_cnt;
  logic [CNT_W+1:0] n_ext;

  // Compare 2*cnt against n with two guard bits so neither side can wrap.
  assign twice_cnt = {1'b0, cnt, 1'b0};
  assign n_ext     = {2'b00, n_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maj_bit <= 1'b0;
    end else if (thresh) begin
      maj_bit <= (twice_cnt > n_ext) | ((twice_cnt == n_ext) & tie_bit);
    end
  end

endmodule

// File: rtl/hv_bundler.sv
// Majority bundler: popcounts num_samples hypervectors, result valid 2 cycles after last beat, held until bundle_ready.
// HV_BUNDLER_TIEBREAK_EN resolves ties with the first sample of the bundle instead of 0.
module hv_bundler #(
  parameter int HV_DIM = hdc_pkg::HV_DIM,
  parameter int CNT_W  = hdc_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              hv_valid,
  input  logic [HV_DIM-1:0] hv_in,
  output logic              hv_ready,
  output logic              bundle_valid,
  output logic [HV_DIM-1:0] bundle_out,
  input  logic              bundle_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  sample_cnt
);
  import hdc_pkg::*;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  bundler_state_e    state, state_nxt;
  logic [CNT_W-1:0]  n_reg;
  logic              start_acc;
  logic              accept;
  logic              last_beat;
  logic [HV_DIM-1:0] tie_vec;

  assign hv_ready     = (state == ACCUM);
  assign bundle_valid = (state == OUT);
  assign busy         = (state != IDLE);
  assign start_acc    = (state == IDLE) && start;
  assign accept       = hv_valid && hv_ready;
  assign last_beat    = accept && ((sample_cnt + ONE) == n_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_samples != '0) ? ACCUM : THRESH;
      ACCUM:   if (last_beat) state_nxt = THRESH;
      THRESH:  state_nxt = OUT;
      OUT:     if (bundle_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg      <= '0;
      sample_cnt <= '0;
    end else if (start_acc) begin
      n_reg      <= num_samples;
      sample_cnt <= '0;
    end else if (accept) begin
      sample_cnt <= sample_cnt + ONE;
    end
  end

`ifdef HV_BUNDLER_TIEBREAK_EN
  logic [HV_DIM-1:0] tb_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_reg <= '0;
    end else if (start_acc) begin
      tb_reg <= '0;
    end else if (accept && (sample_cnt == '0)) begin
      tb_reg <= hv_in;
    end
  end

  assign tie_vec = tb_reg;
`else
  assign tie_vec = '0;
`endif

  for (genvar g = 0; g < HV_DIM; g++) begin : g_dim
    hv_bit_counter #(
      .CNT_W (CNT_W)
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (start_acc),
      .inc     (accept & hv_in[g]),
      .thresh  (state == THRESH),
      .tie_bit (tie_vec[g]),
      .n_reg   (n_reg),
      .maj_bit (bundle_out[g])
    );
  end

endmodule

// File: tb/tb_hv_bundler.sv
// Bench for hv_bundler: constant vector table, hand-written corner sequences, randomized bundles vs a popcount model.
module tb_hv_bundler;
  localparam int D = 64;
  localparam int W = 8;
`ifdef HV_BUNDLER_TIEBREAK_EN
  localparam bit TB_EN = 1'b1;
`else
  localparam bit TB_EN = 1'b0;
`endif
  localparam logic [D-1:0] ONES = {D{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] num_samples = '0;
  logic         hv_valid = 1'b0;
  logic [D-1:0] hv_in = '0;
  logic         hv_ready;
  logic         bundle_valid;
  logic [D-1:0] bundle_out;
  logic         bundle_ready = 1'b0;
  logic         busy;
  logic [W-1:0] sample_cnt;

  int checks = 0;
  int failures = 0;
  logic [D-1:0] beat_q[$];

  typedef struct {
    int           n;
    int           gap;
    int           bp;
    logic [D-1:0] hv [5];
    logic [D-1:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  hv_bundler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .hv_valid     (hv_valid),
    .hv_in        (hv_in),
    .hv_ready     (hv_ready),
    .bundle_valid (bundle_valid),
    .bundle_out   (bundle_out),
    .bundle_ready (bundle_ready),
    .busy         (busy),
    .sample_cnt   (sample_cnt)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Majority by counting ones per dimension; ties follow the first sample when tiebreak is built in.
  function automatic logic [D-1:0] model(input int n);
    logic [D-1:0] r = '0;
    for (int d = 0; d < D; d++) begin
      int c = 0;
      foreach (beat_q[i]) c += int'(beat_q[i][d]);
      if (2 * c > n) r[d] = 1'b1;
      else if (2 * c == n && TB_EN && n > 0) r[d] = beat_q[0][d];
    end
    return r;
  endfunction

  function automatic vec_t mk(input int n, input int gap, input int bp, input logic [D-1:0] exp,
                              input logic [D-1:0] b0 = '0, input logic [D-1:0] b1 = '0,
                              input logic [D-1:0] b2 = '0, input logic [D-1:0] b3 = '0,
                              input logic [D-1:0] b4 = '0);
    vec_t v;
    v.n = n; v.gap = gap; v.bp = bp; v.exp = exp;
    v.hv[0] = b0; v.hv[1] = b1; v.hv[2] = b2; v.hv[3] = b3; v.hv[4] = b4;
    return v;
  endfunction

  // Starts a bundle of beat_q, checks timing and result; gap<0 means random gaps per beat.
  task automatic run_bundle(input int n, input int gap, input int bp, input bit release_out,
                            input logic [D-1:0] exp, input string tag);
    int lat;
    @(negedge clk);
    start = 1'b1;
    num_samples = n[W-1:0];
    @(negedge clk);
    start = 1'b0;
    num_samples = W'($urandom);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        hv_valid = 1'b0;
        hv_in = {$urandom(), $urandom()};
        @(negedge clk);
      end
      if (i == 0 || i == n - 1) check({tag, "_hv_ready"}, 64'(hv_ready), 64'd1);
      hv_valid = 1'b1;
      hv_in = beat_q[i];
      @(negedge clk);
    end
    hv_valid = 1'b0;
    hv_in = {$urandom(), $urandom()};
    check({tag, "_thresh_valid"}, 64'(bundle_valid), 64'd0);
    check({tag, "_thresh_ready"}, 64'(hv_ready), 64'd0);
    check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'(n));
    lat = 0;
    while (!bundle_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd1);
    check({tag, "_bundle_out"}, bundle_out, exp);
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check({tag, "_bp_valid"}, 64'(bundle_valid), 64'd1);
      check({tag, "_bp_out"}, bundle_out, exp);
    end
    if (release_out) begin
      bundle_ready = 1'b1;
      @(negedge clk);
      bundle_ready = 1'b0;
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
      check({tag, "_idle_valid"}, 64'(bundle_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    logic [D-1:0] exp;
    int n;

    vecs[0] = mk(3, 0, 0, ONES, ONES, ONES, ONES);
    vecs[1] = mk(4, 0, 0, TB_EN ? 64'h1 : 64'h0, 64'h1, 64'h1, 64'h0, 64'h0);
    vecs[2] = mk(5, 1, 0, 64'hF0, 64'hF0, 64'hF0, 64'hF0, 64'h0F, 64'h0F);
    vecs[3] = mk(0, 0, 5, 64'h0);
    vecs[4] = mk(1, 0, 2, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
    vecs[5] = mk(2, 0, 0, TB_EN ? 64'hA : 64'h0, 64'hA, 64'h5);

    #1;
    check("rst_hv_ready", 64'(hv_ready), 64'd0);
    check("rst_valid", 64'(bundle_valid), 64'd0);
    check("rst_out", bundle_out, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      beat_q.delete();
      for (int i = 0; i < vecs[v].n; i++) beat_q.push_back(vecs[v].hv[i]);
      run_bundle(vecs[v].n, vecs[v].gap, vecs[v].bp, 1'b1, vecs[v].exp, $sformatf("vec%0d", v));
    end

    // start and hv_valid while parked in OUT, then hv_valid while IDLE: all ignored
    beat_q.delete();
    beat_q.push_back(ONES);
    beat_q.push_back(ONES);
    run_bundle(2, 0, 0, 1'b0, ONES, "hold");
    start = 1'b1;
    num_samples = 8'd3;
    hv_valid = 1'b1;
    hv_in = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("out_ign_valid", 64'(bundle_valid), 64'd1);
      check("out_ign_out", bundle_out, ONES);
      check("out_ign_cnt", 64'(sample_cnt), 64'd2);
    end
    start = 1'b0;
    hv_valid = 1'b0;
    bundle_ready = 1'b1;
    @(negedge clk);
    bundle_ready = 1'b0;
    check("out_ign_idle", 64'(busy), 64'd0);
    hv_valid = 1'b1;
    hv_in = ONES;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_ign_ready", 64'(hv_ready), 64'd0);
      check("idle_ign_cnt", 64'(sample_cnt), 64'd2);
      check("idle_ign_out", bundle_out, ONES);
    end
    hv_valid = 1'b0;
    beat_q.delete();
    beat_q.push_back(64'h0);
    run_bundle(1, 0, 0, 1'b1, 64'h0, "after_idle");

    // asynchronous reset after 2 of 4 beats must leave no residue
    @(negedge clk);
    start = 1'b1;
    num_samples = 8'd4;
    @(negedge clk);
    start = 1'b0;
    hv_valid = 1'b1;
    hv_in = ONES;
    @(negedge clk);
    @(negedge clk);
    hv_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(hv_ready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_cnt", 64'(sample_cnt), 64'd0);
    check("mid_rst_valid", 64'(bundle_valid), 64'd0);
    check("mid_rst_out", bundle_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beat_q.delete();
    beat_q.push_back(64'hA);
    run_bundle(1, 0, 0, 1'b1, 64'hA, "post_rst");

    for (int it = 0; it < 40; it++) begin
      n = (it == 0) ? 255 : (it == 1) ? 254 : int'($urandom_range(0, 9));
      beat_q.delete();
      for (int i = 0; i < n; i++) begin
        logic [D-1:0] b;
        b = {$urandom(), $urandom()};
        if (it % 3 == 0) b = b & {$urandom(), $urandom()};
        beat_q.push_back(b);
      end
      exp = model(n);
      run_bundle(n, -1, int'($urandom_range(0, 3)), 1'b1, exp, $sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hv_bundler.md
# hv_bundler

Bundling stage that sits directly downstream of the 64-lane hypervector generator. It consumes one 64-bit binary hypervector per accepted beat and keeps a per-dimension popcount across a programmable number of samples. It then thresholds each count by majority to produce one bundled 64-bit class/prototype hypervector. The output handshake holds that result until the downstream similarity/storage stage takes it.

## Interface
Parameters:
- `HV_DIM`, 64: hypervector dimensionality, equal to the generator lane count.
- `CNT_W`, 8: per-dimension counter width. It also sets the width of `num_samples`, so the maximum is 255 samples.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a new bundle. Sampled only in IDLE.
- `num_samples` input CNT_W: number of hypervectors to bundle. Captured when `start` is accepted.
- `hv_valid` input 1: `hv_in` carries a valid sample.
- `hv_in` input HV_DIM: sample hypervector from the generator.
- `hv_ready` output 1: stage accepts a sample this cycle.
- `bundle_valid` output 1: `bundle_out` is valid.
- `bundle_out` output HV_DIM: bundled (majority) hypervector.
- `bundle_ready` input 1: downstream consumes `bundle_out`.
- `busy` output 1: the FSM is not in IDLE.
- `sample_cnt` output CNT_W: number of samples accepted in the current bundle.

## Operation
- The FSM has four states: IDLE, ACCUM, THRESH and OUT.
- IDLE:
  - `start`=1 captures `num_samples` into `n_reg`, clears all counters and clears `sample_cnt`.
  - If `num_samples`!=0 the next state is ACCUM; otherwise the next state is THRESH.
- ACCUM:
  - `hv_ready`=1.
  - On each beat with `hv_valid`&&`hv_ready`, `cnt[d] += hv_in[d]` for every d and `sample_cnt` increments.
  - On the beat where `sample_cnt+1 == n_reg`, the next state is THRESH.
- THRESH:
  - `bundle_out[d] <= ({1'b0,cnt[d],1'b0} > {2'b0,n_reg})`, a strict majority compared in CNT_W+2 bits.
  - Tie handling (`2*cnt[d] == n_reg`) is governed by Configuration.
  - Next state is OUT.
- OUT:
  - `bundle_valid`=1 and `bundle_out` stays stable.
  - On `bundle_ready`=1 the next state is IDLE.
- Counters cannot overflow, because at most `n_reg` ≤ 2^CNT_W−1 increments occur.
- `num_samples`=0 produces an all-zero bundle.
- `start` outside IDLE is ignored. `num_samples` changes after capture have no effect.
- `hv_valid` outside ACCUM is ignored and the sample is dropped, because `hv_ready`=0.
- An asynchronous `rst_n` assertion in any state forces IDLE immediately and clears all state.

## Timing
- Reset values: `hv_ready`=0, `bundle_valid`=0, `bundle_out`=0, `busy`=0, `sample_cnt`=0. All counters and `n_reg` are 0.
- `hv_ready` is a registered state decode. It is high from the cycle after `start` acceptance until the cycle of the last beat.
- The last accepted beat is cycle t. THRESH occupies t+1, and `bundle_valid` rises at t+2.
- For `num_samples`=0, `start` at cycle t gives `bundle_valid` at t+2.
- Under backpressure, `bundle_valid` and `bundle_out` are held indefinitely while `bundle_ready`=0.
- The earliest next `start` is accepted the cycle after the `bundle_ready` handshake, once the FSM is back in IDLE.
- Throughput is one sample per cycle in ACCUM. `hv_ready` does not depend combinationally on `hv_valid`.

## Configuration
- `HV_BUNDLER_TIEBREAK_EN` defined:
  - The first accepted sample of each bundle is latched into `tb_reg`.
  - On a tie, `bundle_out[d] = tb_reg[d]`.
  - `tb_reg` resets to 0 and clears on `start`.
- `HV_BUNDLER_TIEBREAK_EN` undefined:
  - A tie yields 0.
  - No `tb_reg` register exists.

## Structure
- Shared package `hdc_pkg` holds:
  - `HV_DIM` and `CNT_W` localparam defaults.
  - `hv_t` typedef (`logic [HV_DIM-1:0]`).
  - `bundler_state_e` enum (IDLE/ACCUM/THRESH/OUT).
- Sub-module `hv_bit_counter`, one instance per dimension via generate. It holds:
  - the CNT_W counter with synchronous clear and increment enable;
  - the registered majority/tie compare.
- The top level holds the FSM, `n_reg`, `sample_cnt` and the optional `tb_reg`.

## Test plan
- `num_samples`=3, three beats of `hv_in`=all-ones → `bundle_out`=64'hFFFF_FFFF_FFFF_FFFF, with `bundle_valid` two cycles after the third beat.
- `num_samples`=4, `hv_in` sequence 64'h1, 64'h1, 64'h0, 64'h0 (dim0 tie) → `bundle_out`=0 without the macro; `bundle_out`=64'h1 with `HV_BUNDLER_TIEBREAK_EN`.
- `num_samples`=5, three beats 64'hF0 and two beats 64'h0F, with `hv_valid` gapped every other cycle → `bundle_out`=64'hF0 and `sample_cnt`=5.
- `num_samples`=0, `start` pulse → `bundle_out`=0 and `bundle_valid` two cycles later. With `bundle_ready` held low 5 cycles, the output stays stable and returns to IDLE the cycle after `ready`.
- `rst_n` asserted mid-ACCUM after 2 of 4 beats → all outputs 0 immediately. A new `start` with 1 beat of 64'hA → `bundle_out`=64'hA, with no residue from the earlier counts.
- `start` asserted while in OUT, plus `hv_valid` pulses in IDLE → both ignored: `sample_cnt` unchanged, `bundle_out` unchanged.
